trailedge_event_fifo: RTL
=========================

Name: trailedge_event_fifo

Overview:
- Consumer stage directly downstream of the trailing-edge retimer. It takes that retimer's per-lane one-cycle pulse vector (already synchronous to clk) and captures every non-zero pulse vector into a small FIFO.
- A processor or sequencer drains the FIFO through a valid/ready interface.
- Each entry can carry a capture timestamp.
- Lost events are flagged and counted.

Parameters:
- Width, 1, number of pulse lanes (matches the retimer's Width).
- Depth, 8, FIFO entries; must be a power of 2, minimum 2.
- TsWidth, 16, timestamp counter width (used only with the optional feature).

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- sres  input  1  synchronous reset, active-high.
- Sync_Pulse_In  input  Width  per-lane one-cycle trailing-edge pulses from the retimer.
- Evt_Data  output  Width  lane vector of the head entry.
- Evt_Ts  output  TsWidth  timestamp of the head entry (present only with the optional feature).
- Evt_Valid  output  1  FIFO non-empty; the head entry is presented.
- Evt_Ready  input  1  consumer accepts the head entry.
- Fifo_Count  output  $clog2(Depth)+1  current occupancy, 0..Depth.
- Overflow  output  1  sticky flag: at least one event was dropped.
- Dropped_Count  output  8  number of dropped events, saturating.
- Overflow_Clr  input  1  one-cycle clear of Overflow and Dropped_Count.

Behaviour:
- Reset (sres=1 at a clk edge):
  - read and write pointers cleared, Fifo_Count=0, Evt_Valid=0;
  - Overflow=0, Dropped_Count=0, timestamp counter=0;
  - Evt_Data=0 and Evt_Ts=0;
  - sres overrides every other input in the same cycle.
  - Reset mid-operation discards all stored entries; no pop is reported.
- Capture:
  - A capture occurs in any cycle where Sync_Pulse_In is non-zero; the entry stores the full vector.
  - An all-zero vector is never stored.
- Pop: occurs when Evt_Valid=1 and Evt_Ready=1. Evt_Ready while empty is ignored.
- Output style: first-word fall-through.
  - Evt_Data and Evt_Ts are read combinationally from the head storage register.
  - Both are forced to 0 when Evt_Valid=0.
- Latency: a pulse captured at edge N into an empty FIFO gives Evt_Valid=1 with that data in the cycle after edge N. There is no bypass path in the same cycle.
- Full with simultaneous pop: if the FIFO is full and a pop occurs in the same cycle as a capture, the capture is accepted. Fifo_Count stays at Depth and no drop is recorded.
- Full without pop: if the FIFO is full and a capture occurs with no pop, the entry is dropped.
  - Overflow is set to 1.
  - Dropped_Count increments, saturating at 255.
- Empty with simultaneous capture: the capture is stored and no pop happens, even if Evt_Ready=1.
- Occupancy: Fifo_Count is registered and changes by +1, -1 or 0 per cycle.
  - Pointers are $clog2(Depth) bits wide and wrap naturally.
  - Full/empty is derived from Fifo_Count.
- Overflow_Clr:
  - clears Overflow and Dropped_Count;
  - if a drop occurs in the same cycle, the drop wins: Overflow=1 and Dropped_Count=1.
- Timestamp counter:
  - free-running, increments every cycle when not in reset;
  - wraps from 2^TsWidth-1 to 0;
  - the value stored is the counter value in the capture cycle, before its own increment.

Optional Feature:
- Macro TRAILEDGE_EVENT_TS_EN.
- Defined: the timestamp counter and the per-entry timestamp storage exist, and the Evt_Ts port is present. Entries are Width+TsWidth bits.
- Undefined: the Evt_Ts port, the timestamp counter and the timestamp storage are all absent; entries are Width bits. All other behaviour is identical.

Test Plan:
- Reset check: assert sres for 2 cycles while Sync_Pulse_In=1 -> Evt_Valid=0, Fifo_Count=0, Overflow=0, Dropped_Count=0, Evt_Data=0 after release.
- Single event (Width=4, Evt_Ready=0): pulse 4'b0101 at edge N -> Evt_Valid=1 and Evt_Data=4'b0101 from cycle N+1, Fifo_Count=1. With TS_EN defined and sres released 10 cycles earlier, Evt_Ts=10. Then Evt_Ready=1 for one cycle -> Evt_Valid=0, Fifo_Count=0.
- Ordering with gaps: pulses 1, 0, 2, 4, 8 on consecutive cycles with Evt_Ready=0, then drain -> outputs 1, 2, 4, 8 in order; the zero vector is not stored; Fifo_Count peaks at 4.
- Overflow (Depth=8): 10 consecutive non-zero pulses with Evt_Ready=0 -> Fifo_Count=8, Overflow=1, Dropped_Count=2, and the first 8 values drain in order. Next, pulse Overflow_Clr alone -> Overflow=0, Dropped_Count=0. Then fill again and pulse Overflow_Clr in the same cycle as a drop -> Overflow=1, Dropped_Count=1.
- Full with simultaneous pop: FIFO full, capture vector 3 with Evt_Ready=1 in the same cycle -> Fifo_Count stays 8, no drop, and vector 3 appears as the last entry drained.
- Wrap-around: 3×Depth events streamed with Evt_Ready=1 continuously plus random stalls -> data order preserved across pointer wrap; with TS_EN and TsWidth=4, timestamps wrap 15→0 correctly.

Source files
------------

// File: rtl/trailedge_event_fifo_if.sv
// Consumer-side handshake bundle for trailedge_event_fifo: head entry, valid and ready.
// Evt_Ts exists only when TRAILEDGE_EVENT_TS_EN is defined.
interface trailedge_event_fifo_if #(
  parameter int Width = 1
`ifdef TRAILEDGE_EVENT_TS_EN
  , parameter int TsWidth = 16
`endif
);
  logic [Width-1:0]   Evt_Data;
`ifdef TRAILEDGE_EVENT_TS_EN
  logic [TsWidth-1:0] Evt_Ts;
`endif
  logic               Evt_Valid;
  logic               Evt_Ready;

  modport master (
    output Evt_Data,
`ifdef TRAILEDGE_EVENT_TS_EN
    output Evt_Ts,
`endif
    output Evt_Valid,
    input  Evt_Ready
  );

  modport slave (
    input  Evt_Data,
`ifdef TRAILEDGE_EVENT_TS_EN
    input  Evt_Ts,
`endif
    input  Evt_Valid,
    output Evt_Ready
  );
endinterface

// File: rtl/trailedge_event_fifo.sv
// Captures every non-zero retimer pulse vector into a first-word-fall-through FIFO with drop accounting.
// Optional capture timestamps per entry when TRAILEDGE_EVENT_TS_EN is defined.
module trailedge_event_fifo #(
  parameter int Width = 1,
  parameter int Depth = 8
`ifdef TRAILEDGE_EVENT_TS_EN
  , parameter int TsWidth = 16
`endif
) (
  input  logic                   clk,
  input  logic                   sres,
  input  logic [Width-1:0]       Sync_Pulse_In,
  trailedge_event_fifo_if.master evt,
  output logic [$clog2(Depth):0] Fifo_Count,
  output logic                   Overflow,
  output logic [7:0]             Dropped_Count,
  input  logic                   Overflow_Clr
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] CntFull = (AW+1)'(Depth);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [7:0]       r_dropped;
  logic [Width-1:0] r_mem_data [Depth];

  logic w_empty;
  logic w_full;
  logic w_capture;
  logic w_pop;
  logic w_push;
  logic w_drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CntFull);
  assign w_capture = |Sync_Pulse_In;
  assign w_pop     = !w_empty && evt.Evt_Ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (sres) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop in the clear cycle restarts the tally at one instead of clearing it.
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_dropped  <= Overflow_Clr ? 8'd1 : sat_inc8(r_dropped);
      end else if (Overflow_Clr) begin
        r_overflow <= 1'b0;
        r_dropped  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sres && w_push) r_mem_data[r_wptr] <= Sync_Pulse_In;
  end

  assign evt.Evt_Valid = !w_empty;
  assign evt.Evt_Data  = w_empty ? '0 : r_mem_data[r_rptr];

`ifdef TRAILEDGE_EVENT_TS_EN
  logic [TsWidth-1:0] r_ts;
  logic [TsWidth-1:0] r_mem_ts [Depth];

  always_ff @(posedge clk) begin
    if (sres) r_ts <= '0;
    else      r_ts <= r_ts + 1'b1;
  end

  // Entries record the counter value of the capture cycle, before it advances.
  always_ff @(posedge clk) begin
    if (!sres && w_push) r_mem_ts[r_wptr] <= r_ts;
  end

  assign evt.Evt_Ts = w_empty ? '0 : r_mem_ts[r_rptr];
`endif

  assign Fifo_Count    = r_count;
  assign Overflow      = r_overflow;
  assign Dropped_Count = r_dropped;

endmodule
